// File: rtl/brom_image_fetch_ctrl_if.sv
// Handshake bundle between the image fetch controller, the pixel ROM and the NN input stage.
// slave = controller side, master = environment (start source, ROM, pixel consumer).
interface brom_image_fetch_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 6,
  parameter int PIX_W  = 10
);
  logic              start_i;
  logic [IDX_W-1:0]  img_idx_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_dout_i;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic [DATA_W-1:0] pix_data_o;
  logic [PIX_W-1:0]  pix_idx_o;
  logic              pix_last_o;

  modport slave (
    input  start_i, img_idx_i, rom_dout_i, pix_ready_i,
    output busy_o, done_o, err_o, rom_en_o, rom_addr_o,
           pix_valid_o, pix_data_o, pix_idx_o, pix_last_o
  );

  modport master (
    output start_i, img_idx_i, rom_dout_i, pix_ready_i,
    input  busy_o, done_o, err_o, rom_en_o, rom_addr_o,
           pix_valid_o, pix_data_o, pix_idx_o, pix_last_o
  );
endinterface

// File: rtl/brom_image_fetch_ctrl.sv
// Streams one 784-pixel image from the block ROM; first pixel ROM_LAT+1 cycles after start.
// Reads are credit-gated against in-flight + FIFO occupancy, so pix_ready_i stalls never drop a ROM word.
module brom_image_fetch_ctrl #(
  parameter int PIX_PER_IMG = 784,
  parameter int NUM_IMG     = 40,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int ROM_LAT     = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  brom_image_fetch_ctrl_if.slave io_bus
);

  localparam int PIX_W = $clog2(PIX_PER_IMG);
  localparam int IDX_W = 6;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_PER_IMG - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [PIX_W-1:0]  r_rd_cnt;
  logic [PIX_W-1:0]  r_pix_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [ROM_LAT-1:0] r_tag;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   r_fcnt;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];

  logic             w_idx_ok;
  logic             w_start_ok;
  logic             w_start_bad;
  logic [CNT_W:0]   w_credit_used;
  logic             w_issue;
  logic             w_ret;
  logic             w_empty;
  logic             w_pix_vld;
  logic             w_hs;
  logic             w_last_hs;
  logic             w_push;
  logic             w_pop;

  assign w_idx_ok    = ({1'b0, io_bus.img_idx_i} < (IDX_W + 1)'(NUM_IMG));
  assign w_start_ok  = (r_state == S_IDLE) && io_bus.start_i && w_idx_ok;
  assign w_start_bad = (r_state == S_IDLE) && io_bus.start_i && !w_idx_ok;

  // Every issued read already owns a FIFO slot, so a return can always be written.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_fcnt};
  assign w_issue       = (r_state == S_FETCH) && (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_ret         = r_tag[ROM_LAT-1];

  // Returning data bypasses an empty FIFO, which is what gives ROM_LAT+1 start-to-pixel latency.
  assign w_empty   = (r_fcnt == '0);
  assign w_pix_vld = !w_empty || w_ret;
  assign w_hs      = w_pix_vld && io_bus.pix_ready_i;
  assign w_last_hs = w_hs && (r_pix_idx == LAST_PIX);
  assign w_pop     = !w_empty && io_bus.pix_ready_i;
  assign w_push    = w_ret && !(w_empty && io_bus.pix_ready_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_rd_cnt  <= '0;
      r_pix_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err  <= w_start_bad;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state   <= S_FETCH;
            r_base    <= ADDR_W'(io_bus.img_idx_i) * ADDR_W'(PIX_PER_IMG);
            r_rd_cnt  <= '0;
            r_pix_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (r_rd_cnt == LAST_PIX) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_hs) begin
        r_pix_idx <= w_last_hs ? '0 : r_pix_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag      <= '0;
      r_inflight <= '0;
      r_fcnt     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_tag      <= ROM_LAT'({r_tag, w_issue});
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_ret);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= io_bus.rom_dout_i;
    end
  end

  assign io_bus.busy_o      = r_busy;
  assign io_bus.done_o      = r_done;
  assign io_bus.err_o       = r_err;
  assign io_bus.rom_en_o    = w_issue;
  assign io_bus.rom_addr_o  = r_base + ADDR_W'(r_rd_cnt);
  assign io_bus.pix_valid_o = w_pix_vld;
  assign io_bus.pix_data_o  = !w_empty ? r_mem[r_rptr] : (w_ret ? io_bus.rom_dout_i : '0);
  assign io_bus.pix_idx_o   = r_pix_idx;
  assign io_bus.pix_last_o  = w_pix_vld && (r_pix_idx == LAST_PIX);

endmodule
